dmem_sram_bridge: RTL and testbench

//  Data-side bus adapter directly downstream of the datapath memory stage.

---
 rtl/dmem_sram_bridge.sv | 123 ++++++++++++
 tb/tb_dmem_sram_bridge.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_sram_bridge.sv
// Data-side bridge from the memory stage to an SRAM-like bus: one transaction
// per request, completion held until the stage advances, and flushed accesses absorbed.
module dmem_sram_bridge #(
  parameter bit UNMAP_KSEG = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m_valid,
  input  logic        m_wr,
  input  logic [1:0]  m_size,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        m_advance,
  input  logic        flush,
  output logic [31:0] rd,
  output logic        d_data_ok,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic [31:0] data_rdata,
  input  logic        data_data_ok
);

  // Handshake: data_req is held with stable fields until data_addr_ok is seen
  // in the same cycle; exactly one data_data_ok then closes the transaction.
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_abort;
  logic        w_abort_nxt;
  logic        w_rd_load;
  logic        w_issue;
  logic [31:0] w_phys_addr;
  logic [31:0] r_rd;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  // kseg0/kseg1 both fold onto the low 512 MB of physical space.
  assign w_phys_addr = (UNMAP_KSEG && (m_addr[31:30] == 2'b10))
                     ? {3'b000, m_addr[28:0]} : m_addr;

  assign w_issue = (r_state == S_IDLE) && m_valid && !flush;

  always_comb begin
    w_state_nxt = r_state;
    w_abort_nxt = r_abort;
    w_rd_load   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_state_nxt = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        // A flushed request is still carried through so the bus sees it once.
        if (flush)        w_abort_nxt = 1'b1;
        if (data_addr_ok) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) begin
          if (r_abort || flush) begin
            w_abort_nxt = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_rd_load   = 1'b1;
            w_state_nxt = S_DONE;
          end
        end else if (flush) begin
          w_abort_nxt = 1'b1;
        end
      end
      S_DONE: begin
        if (m_advance || flush) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_abort <= 1'b0;
      r_rd    <= 32'h0;
      r_wr    <= 1'b0;
      r_size  <= 2'b00;
      r_addr  <= 32'h0;
      r_wdata <= 32'h0;
    end else begin
      r_state <= w_state_nxt;
      r_abort <= w_abort_nxt;
      if (w_issue) begin
        r_wr    <= m_wr;
        r_size  <= m_size;
        r_addr  <= w_phys_addr;
        r_wdata <= m_wdata;
      end
      if (w_rd_load) r_rd <= data_rdata;
    end
  end

  always_comb begin
    data_req = w_issue || (r_state == S_REQ);
    if (r_state == S_IDLE) begin
      data_wr    = m_wr;
      data_size  = m_size;
      data_addr  = w_phys_addr;
      data_wdata = m_wdata;
    end else begin
      data_wr    = r_wr;
      data_size  = r_size;
      data_addr  = r_addr;
      data_wdata = r_wdata;
    end
  end

  assign d_data_ok = (r_state == S_DONE);
  assign rd        = r_rd;

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Directed bench for dmem_sram_bridge: cycle-by-cycle stimulus with the SRAM side
// driven by hand and every expected value written out as a constant.
module tb_dmem_sram_bridge;

  logic        clk;
  logic        resetn;
  logic        m_valid;
  logic        m_wr;
  logic [1:0]  m_size;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic        m_advance;
  logic        flush;
  logic [31:0] rd;
  logic        d_data_ok;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic [31:0] data_rdata;
  logic        data_data_ok;

  int n_assert;
  int n_fail;
  int req_cnt;

  dmem_sram_bridge #(.UNMAP_KSEG(1'b1)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .m_valid      (m_valid),
    .m_wr         (m_wr),
    .m_size       (m_size),
    .m_addr       (m_addr),
    .m_wdata      (m_wdata),
    .m_advance    (m_advance),
    .flush        (flush),
    .rd           (rd),
    .d_data_ok    (d_data_ok),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_rdata   (data_rdata),
    .data_data_ok (data_data_ok)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // request-cycle counter sampled on the inactive edge
  always @(negedge clk) if (data_req === 1'b1) req_cnt++;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic v, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    m_valid = v;
    m_wr    = wr;
    m_size  = sz;
    m_addr  = a;
    m_wdata = wd;
  endtask

  task automatic drive_bus(input logic aok, input logic dok, input logic [31:0] rdat);
    data_addr_ok = aok;
    data_data_ok = dok;
    data_rdata   = rdat;
  endtask

  // scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic req, input logic dok,
                         input logic [31:0] r);
    #1;
    chk({tag, "_req"}, {31'h0, data_req}, {31'h0, req});
    chk({tag, "_dok"}, {31'h0, d_data_ok}, {31'h0, dok});
    chk({tag, "_rd"}, rd, r);
  endtask

  task automatic chk_fields(input string tag, input logic wr, input logic [1:0] sz,
                            input logic [31:0] a, input logic [31:0] wd);
    chk({tag, "_wr"}, {31'h0, data_wr}, {31'h0, wr});
    chk({tag, "_size"}, {30'h0, data_size}, {30'h0, sz});
    chk({tag, "_addr"}, data_addr, a);
    chk({tag, "_wdata"}, data_wdata, wd);
  endtask

  int base;

  initial begin
    n_assert = 0;
    n_fail   = 0;
    req_cnt  = 0;
    resetn   = 1'b0;
    m_advance = 1'b0;
    flush     = 1'b0;
    drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    drive_bus(1'b0, 1'b0, 32'h0);
    repeat (2) cyc();
    chk_out("reset", 1'b0, 1'b0, 32'h0);
    chk_fields("reset", 1'b0, 2'd0, 32'h0, 32'h0);
    resetn = 1'b1;

    // flush while the request is waiting for addr_ok
    base = req_cnt;
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'h0000_2000, 32'h0);
    chk_out("t3_c0", 1'b1, 1'b0, 32'h0);
    cyc(); flush = 1'b1;
    chk_out("t3_c1", 1'b1, 1'b0, 32'h0);
    cyc(); flush = 1'b0; drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t3_c2", 1'b1, 1'b0, 32'h0);
    chk("t3_c2_addr", data_addr, 32'h0000_2000);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0000_1234);
    chk_out("t3_c3", 1'b0, 1'b0, 32'h0);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0);
    chk_out("t3_c4", 1'b0, 1'b0, 32'h0);
    cyc();
    chk_out("t3_c5", 1'b0, 1'b0, 32'h0);
    chk("t3_req_cycles", req_cnt - base, 32'd3);

    // load word, addr_ok at issue, data_ok two cycles later, stage stalled 3 cycles
    base = req_cnt;
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'hC000_1000, 32'h0); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t1_c0", 1'b1, 1'b0, 32'h0);
    chk_fields("t1_c0", 1'b0, 2'd2, 32'hC000_1000, 32'h0);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0);
    chk_out("t1_c1", 1'b0, 1'b0, 32'h0);
    cyc(); drive_bus(1'b0, 1'b1, 32'hDEAD_BEEF);
    chk_out("t1_c2", 1'b0, 1'b0, 32'h0);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0);
    chk_out("t1_c3", 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc();
    chk_out("t1_c4", 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc();
    chk_out("t1_c5", 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc(); m_advance = 1'b1;
    chk_out("t1_c6", 1'b0, 1'b1, 32'hDEAD_BEEF);
    cyc(); m_advance = 1'b0; drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t1_c7", 1'b0, 1'b0, 32'hDEAD_BEEF);
    chk("t1_req_cycles", req_cnt - base, 32'd1);

    // store byte to kseg1, addr_ok after three wait cycles, inputs disturbed meanwhile
    base = req_cnt;
    cyc(); drive_m(1'b1, 1'b1, 2'd0, 32'hBFC0_0003, 32'hAB00_0000);
    chk_out("t2_c0", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_fields("t2_c0", 1'b1, 2'd0, 32'h1FC0_0003, 32'hAB00_0000);
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0);
    chk_out("t2_c1", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_fields("t2_c1", 1'b1, 2'd0, 32'h1FC0_0003, 32'hAB00_0000);
    cyc(); drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t2_c2", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_fields("t2_c2", 1'b1, 2'd0, 32'h1FC0_0003, 32'hAB00_0000);
    cyc(); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t2_c3", 1'b1, 1'b0, 32'hDEAD_BEEF);
    chk_fields("t2_c3", 1'b1, 2'd0, 32'h1FC0_0003, 32'hAB00_0000);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0000_0055);
    chk_out("t2_c4", 1'b0, 1'b0, 32'hDEAD_BEEF);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); m_advance = 1'b1;
    chk_out("t2_c5", 1'b0, 1'b1, 32'h0000_0055);
    cyc(); m_advance = 1'b0;
    chk_out("t2_c6", 1'b0, 1'b0, 32'h0000_0055);
    chk("t2_req_cycles", req_cnt - base, 32'd4);

    // back-to-back loads, second issue the cycle after leaving DONE
    base = req_cnt;
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'h8000_0100, 32'h0); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t5_c0", 1'b1, 1'b0, 32'h0000_0055);
    chk("t5_c0_addr", data_addr, 32'h0000_0100);
    cyc(); drive_bus(1'b0, 1'b1, 32'hA1A1_A1A1);
    chk_out("t5_c1", 1'b0, 1'b0, 32'h0000_0055);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); m_advance = 1'b1;
    chk_out("t5_c2", 1'b0, 1'b1, 32'hA1A1_A1A1);
    cyc(); m_advance = 1'b0; drive_m(1'b1, 1'b0, 2'd2, 32'h8000_0104, 32'h0);
    drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t5_c3", 1'b1, 1'b0, 32'hA1A1_A1A1);
    chk("t5_c3_addr", data_addr, 32'h0000_0104);
    cyc(); drive_bus(1'b0, 1'b1, 32'hB2B2_B2B2);
    chk_out("t5_c4", 1'b0, 1'b0, 32'hA1A1_A1A1);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); m_advance = 1'b1;
    chk_out("t5_c5", 1'b0, 1'b1, 32'hB2B2_B2B2);
    cyc(); m_advance = 1'b0; drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t5_c6", 1'b0, 1'b0, 32'hB2B2_B2B2);
    chk("t5_req_cycles", req_cnt - base, 32'd2);

    // flush in WAIT, next instruction held until the stale data_ok drains
    base = req_cnt;
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'h0000_0300, 32'h0); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t4_c0", 1'b1, 1'b0, 32'hB2B2_B2B2);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); flush = 1'b1;
    chk_out("t4_c1", 1'b0, 1'b0, 32'hB2B2_B2B2);
    cyc(); flush = 1'b0; drive_m(1'b1, 1'b0, 2'd2, 32'h0000_0400, 32'h0);
    chk_out("t4_c2", 1'b0, 1'b0, 32'hB2B2_B2B2);
    cyc();
    chk_out("t4_c3", 1'b0, 1'b0, 32'hB2B2_B2B2);
    cyc(); drive_bus(1'b0, 1'b1, 32'hDEAD_0000);
    chk_out("t4_c4", 1'b0, 1'b0, 32'hB2B2_B2B2);
    cyc(); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t4_c5", 1'b1, 1'b0, 32'hB2B2_B2B2);
    chk("t4_c5_addr", data_addr, 32'h0000_0400);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0000_4444);
    chk_out("t4_c6", 1'b0, 1'b0, 32'hB2B2_B2B2);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); m_advance = 1'b1;
    chk_out("t4_c7", 1'b0, 1'b1, 32'h0000_4444);
    cyc(); m_advance = 1'b0; drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t4_c8", 1'b0, 1'b0, 32'h0000_4444);
    chk("t4_req_cycles", req_cnt - base, 32'd2);

    // asynchronous reset while waiting for data
    cyc(); drive_m(1'b1, 1'b1, 2'd1, 32'h0000_0500, 32'h0000_5555); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t6_c0", 1'b1, 1'b0, 32'h0000_4444);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0);
    chk_out("t6_c1", 1'b0, 1'b0, 32'h0000_4444);
    chk_fields("t6_c1", 1'b1, 2'd1, 32'h0000_0500, 32'h0000_5555);
    resetn = 1'b0;
    drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t6_rst", 1'b0, 1'b0, 32'h0);
    chk_fields("t6_rst", 1'b0, 2'd0, 32'h0, 32'h0);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0000_9999);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); resetn = 1'b1;
    chk_out("t6_rel", 1'b0, 1'b0, 32'h0);
    cyc(); drive_m(1'b1, 1'b0, 2'd2, 32'h0000_0600, 32'h0); drive_bus(1'b1, 1'b0, 32'h0);
    chk_out("t6_c2", 1'b1, 1'b0, 32'h0);
    chk("t6_c2_addr", data_addr, 32'h0000_0600);
    cyc(); drive_bus(1'b0, 1'b1, 32'h0000_0066);
    chk_out("t6_c3", 1'b0, 1'b0, 32'h0);
    cyc(); drive_bus(1'b0, 1'b0, 32'h0); m_advance = 1'b1;
    chk_out("t6_c4", 1'b0, 1'b1, 32'h0000_0066);
    cyc(); m_advance = 1'b0; drive_m(1'b0, 1'b0, 2'd0, 32'h0, 32'h0);
    chk_out("t6_c5", 1'b0, 1'b0, 32'h0000_0066);

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
